// File: rtl/load_use_hazard_ctrl.sv
// Load-use hazard and branch-flush controller for the 5-stage pipeline.
// The first stall/flush cycle is decided combinationally in IDLE; extra cycles come from the FSM.
module load_use_hazard_ctrl #(
    parameter int unsigned STALL_CYCLES = 1,
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_Rs,
    input  logic [4:0]       id_Rt,
    input  logic             id_use_rt,
    input  logic [4:0]       ex_Rt,
    input  logic             ex_MemtoReg,
    input  logic             ex_RegWr,
    input  logic             br_taken,
    output logic             pc_wr,
    output logic             ifid_wr,
    output logic             ifid_flush,
    output logic             load_used,
    output logic             busy,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {IDLE, STALL, FLUSH} state_t;

    localparam logic [2:0]       STALL_REM = 3'(STALL_CYCLES - 1);
    localparam logic [2:0]       FLUSH_REM = 3'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_t           state_q, state_d;
    logic [2:0]       rem_q, rem_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             haz;

    // $zero is never a real dependence; rt only matters when ID actually reads it.
    always_comb begin
        haz = ex_MemtoReg && ex_RegWr && (ex_Rt != 5'd0) &&
              ((ex_Rt == id_Rs) || (id_use_rt && (ex_Rt == id_Rt)));
    end

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        pc_wr       = 1'b1;
        ifid_wr     = 1'b1;
        ifid_flush  = 1'b0;
        load_used   = 1'b0;
        case (state_q)
            IDLE: begin
                if (br_taken) begin
                    ifid_flush = 1'b1;
                    if (flush_cnt_q != CNT_MAX) flush_cnt_d = flush_cnt_q + 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_d = FLUSH;
                        rem_d   = FLUSH_REM;
                    end
                end else if (haz) begin
                    load_used = 1'b1;
                    pc_wr     = 1'b0;
                    ifid_wr   = 1'b0;
                    if (stall_cnt_q != CNT_MAX) stall_cnt_d = stall_cnt_q + 1'b1;
                    if (STALL_CYCLES > 1) begin
                        state_d = STALL;
                        rem_d   = STALL_REM;
                    end
                end
            end
            STALL: begin
                load_used = 1'b1;
                pc_wr     = 1'b0;
                ifid_wr   = 1'b0;
                rem_d     = rem_q - 3'd1;
                if (rem_q == 3'd1) state_d = IDLE;
            end
            FLUSH: begin
                ifid_flush = 1'b1;
                rem_d      = rem_q - 3'd1;
                if (rem_q == 3'd1) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                rem_d   = '0;
            end
        endcase
        // While reset is held the Mealy path must not leak hazard/branch inputs.
        if (!rst) begin
            pc_wr      = 1'b1;
            ifid_wr    = 1'b1;
            ifid_flush = 1'b0;
            load_used  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    always_comb begin
        busy      = (state_q != IDLE);
        stall_cnt = stall_cnt_q;
        flush_cnt = flush_cnt_q;
    end

endmodule
